// File: rtl/uncached_store_queue.sv
// Program-ordered queue of uncached stores feeding mem_write as single-beat writes,
// with an in-flight address FIFO for load-after-store hazard checks and drain tracking.
// o_req packing (MSB..LSB): addr[31:0], len[7:0], size[2:0], wen[3:0].
module uncached_store_queue #(
  parameter int DEPTH          = 4,
  parameter int INFLIGHT_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_st_valid,
  output logic        o_st_ready,
  input  logic [31:0] i_st_addr,
  input  logic [31:0] i_st_data,
  input  logic [3:0]  i_st_wstrb,
  input  logic [2:0]  i_st_size,
  output logic        o_we,
  output logic [46:0] o_req,
  output logic [31:0] o_data,
  input  logic        i_sram_full,
  input  logic        i_sram_end,
  input  logic [31:0] i_ld_addr,
  output logic        o_ld_conflict,
  output logic        o_idle,
  output logic        o_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(INFLIGHT_DEPTH);
  localparam logic [AW:0] Q_FULL  = DEPTH[AW:0];
  localparam logic [IW:0] IF_FULL = INFLIGHT_DEPTH[IW:0];

  logic [31:0]   q_addr  [DEPTH];
  logic [31:0]   q_data  [DEPTH];
  logic [3:0]    q_wstrb [DEPTH];
  logic [2:0]    q_size  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic [29:0]   if_addr [INFLIGHT_DEPTH];
  logic [IW-1:0] if_wr, if_rd;
  logic [IW:0]   if_count;

  logic          accept, issue, end_ok;
  logic [AW-1:0] q_off;
  logic [IW-1:0] f_off;
  logic          unused_ld_lsb;

  assign unused_ld_lsb = ^i_ld_addr[1:0];

  assign o_st_ready = (count != Q_FULL);
  assign accept     = i_st_valid && o_st_ready;
  assign end_ok     = i_sram_end && (if_count != '0);
  // A completion in this same cycle frees its slot for the issue decision.
  assign issue      = (count != '0) && !i_sram_full && !o_we &&
                      ((if_count != IF_FULL) || end_ok);
  assign o_idle     = (count == '0) && !o_we && (if_count == '0);

  always_comb begin
    o_ld_conflict = 1'b0;
    q_off         = '0;
    f_off         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      q_off = AW'(i) - rd_ptr;
      if (({1'b0, q_off} < count) && (q_addr[i][31:2] == i_ld_addr[31:2]))
        o_ld_conflict = 1'b1;
    end
    for (int j = 0; j < INFLIGHT_DEPTH; j++) begin
      f_off = IW'(j) - if_rd;
      if (({1'b0, f_off} < if_count) && (if_addr[j] == i_ld_addr[31:2]))
        o_ld_conflict = 1'b1;
    end
  end

  // Storage arrays carry no reset; validity is defined by pointers and counts.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      q_addr[wr_ptr]  <= i_st_addr;
      q_data[wr_ptr]  <= i_st_data;
      q_wstrb[wr_ptr] <= i_st_wstrb;
      q_size[wr_ptr]  <= i_st_size;
    end
    if (issue)
      if_addr[if_wr] <= q_addr[rd_ptr][31:2];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      if_wr       <= '0;
      if_rd       <= '0;
      if_count    <= '0;
      o_we        <= 1'b0;
      o_req       <= '0;
      o_data      <= '0;
      o_underflow <= 1'b0;
    end else begin
      o_we <= issue;
      if (accept)
        wr_ptr <= wr_ptr + AW'(1);
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
        if_wr  <= if_wr + IW'(1);
        o_req  <= {q_addr[rd_ptr], 8'd0, q_size[rd_ptr], q_wstrb[rd_ptr]};
        o_data <= q_data[rd_ptr];
      end
      if (end_ok)
        if_rd <= if_rd + IW'(1);
      if (i_sram_end && (if_count == '0))
        o_underflow <= 1'b1;

      if (accept && !issue)
        count <= count + (AW+1)'(1);
      else if (!accept && issue)
        count <= count - (AW+1)'(1);

      if (issue && !end_ok)
        if_count <= if_count + (IW+1)'(1);
      else if (!issue && end_ok)
        if_count <= if_count - (IW+1)'(1);
    end
  end
endmodule

// File: tb/tb_uncached_store_queue.sv
// Bench for uncached_store_queue: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based transaction model.
module tb_uncached_store_queue;
  localparam int DEPTH = 4;
  localparam int IFD   = 4;
  localparam int W     = 71;  // {addr[70:39], data[38:7], wstrb[6:3], size[2:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [3:0]  st_wstrb;
  logic [2:0]  st_size;
  logic        we;
  logic [46:0] req;
  logic [31:0] data;
  logic        sram_full, sram_end;
  logic [31:0] ld_addr;
  logic        ld_conflict, idle, underflow;

  uncached_store_queue #(.DEPTH(DEPTH), .INFLIGHT_DEPTH(IFD)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_st_valid(st_valid), .o_st_ready(st_ready),
    .i_st_addr(st_addr), .i_st_data(st_data), .i_st_wstrb(st_wstrb), .i_st_size(st_size),
    .o_we(we), .o_req(req), .o_data(data),
    .i_sram_full(sram_full), .i_sram_end(sram_end),
    .i_ld_addr(ld_addr), .o_ld_conflict(ld_conflict),
    .o_idle(idle), .o_underflow(underflow)
  );

  // Reference model: pending stores in program order, issued word addresses awaiting completion.
  logic [W-1:0] exp_q[$];
  logic [31:0]  if_q[$];
  logic         m_we, m_underflow;
  logic [46:0]  m_req;
  logic [31:0]  m_data;
  bit           model_valid = 0;
  int           checks = 0, errors = 0, cyc = 0;
  int           we_cycles[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic m_conflict(input logic [31:0] a);
    foreach (exp_q[i]) if (exp_q[i][70:41] == a[31:2]) return 1'b1;
    foreach (if_q[i])  if (if_q[i][31:2]  == a[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  // Called just after a falling edge with inputs set; checks, advances the model, waits a cycle.
  task automatic tick();
    logic acc, eok, iss;
    logic [W-1:0] e;
    #1;
    if (model_valid) begin
      check("st_ready",    st_ready,    exp_q.size() < DEPTH);
      check("idle",        idle,        exp_q.size() == 0 && !m_we && if_q.size() == 0);
      check("ld_conflict", ld_conflict, m_conflict(ld_addr));
      check("we",          we,          m_we);
      check("req",         req,         m_req);
      check("data",        data,        m_data);
      check("underflow",   underflow,   m_underflow);
    end
    if (rst) begin
      exp_q.delete();
      if_q.delete();
      m_we = 0; m_req = '0; m_data = '0; m_underflow = 0;
      model_valid = 1;
    end else if (model_valid) begin
      acc = st_valid && exp_q.size() < DEPTH;
      eok = sram_end && if_q.size() > 0;
      iss = exp_q.size() > 0 && !sram_full && !m_we && (if_q.size() - int'(eok) < IFD);
      if (sram_end && !eok) m_underflow = 1;
      if (eok) void'(if_q.pop_front());
      m_we = iss;
      if (iss) begin
        e = exp_q.pop_front();
        m_req  = {e[70:39], 8'd0, e[2:0], e[6:3]};
        m_data = e[38:7];
        if_q.push_back(e[70:39]);
      end
      if (acc) exp_q.push_back({st_addr, st_data, st_wstrb, st_size});
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic quiet();
    st_valid = 0; sram_full = 0; sram_end = 0; rst = 0;
  endtask

  task automatic rand_store();
    st_valid = 1;
    st_addr  = 32'h1FD0_0000 + 32'(($urandom_range(0, 7) * 4) + $urandom_range(0, 3));
    st_data  = $urandom;
    st_wstrb = 4'($urandom_range(1, 15));
    st_size  = 3'($urandom_range(0, 2));
  endtask

  task automatic drain(input int n);
    st_valid = 0; sram_full = 0;
    for (int i = 0; i < n; i++) begin
      sram_end = (if_q.size() > 0);
      tick();
    end
    sram_end = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    quiet();
    st_addr = '0; st_data = '0; st_wstrb = '0; st_size = '0; ld_addr = 32'h1FC0_0010;
    @(negedge clk);
    rst = 1; tick(); rst = 0;

    // Single store: o_we two cycles after acceptance.
    st_valid = 1; st_addr = 32'h1FC0_0010; st_data = 32'hDEAD_BEEF; st_wstrb = 4'hF; st_size = 3'd2;
    tick();
    st_valid = 0;
    tick();
    check("single_we",   we,   1);
    check("single_req",  req,  {32'h1FC0_0010, 8'd0, 3'd2, 4'hF});
    check("single_data", data, 32'hDEAD_BEEF);
    check("single_busy", idle, 0);
    tick();
    sram_end = 1; tick(); sram_end = 0;
    check("single_idle", idle, 1);

    // Full queue: six offered with the SRAM side full, four accepted.
    sram_full = 1;
    for (int i = 0; i < 6; i++) begin rand_store(); tick(); end
    st_valid = 0;
    check("full_ready", st_ready, 0);
    sram_full = 0;
    we_cycles.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (we) we_cycles.push_back(cyc);
    end
    check("full_we_count", we_cycles.size(), 4);
    for (int i = 1; i < we_cycles.size(); i++)
      check("full_we_spacing", we_cycles[i] - we_cycles[i-1], 2);
    drain(6);

    // Load hazard against an in-flight store.
    st_valid = 1; st_addr = 32'h1FD0_0004; st_data = 32'h1234_5678; st_wstrb = 4'h3; st_size = 3'd1;
    tick(); st_valid = 0; tick(); tick();
    ld_addr = 32'h1FD0_0006; #1; check("ld_hit",  ld_conflict, 1);
    ld_addr = 32'h1FD0_0008; #1; check("ld_miss", ld_conflict, 0);
    sram_end = 1; tick(); sram_end = 0;
    ld_addr = 32'h1FD0_0006; #1; check("ld_cleared", ld_conflict, 0);

    // In-flight limit: fifth store holds until a completion frees a slot.
    for (int i = 0; i < 5; i++) begin rand_store(); tick(); end
    st_valid = 0;
    for (int i = 0; i < 10; i++) tick();
    check("limit_held", we, 0);
    sram_end = 1; tick(); sram_end = 0;
    check("limit_release_we", we, 1);
    drain(8);

    // Random traffic: overlapping accept/issue/completion and pointer wrap.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) rand_store(); else st_valid = 0;
      sram_full = ($urandom_range(0, 3) == 0);
      sram_end  = (if_q.size() > 0) && ($urandom_range(0, 1) == 1);
      ld_addr   = 32'h1FD0_0000 + 32'(($urandom_range(0, 7) * 4) + $urandom_range(0, 3));
      tick();
    end
    drain(12);

    // Reset mid-operation (two in flight, three queued), then a spurious completion.
    for (int i = 0; i < 2; i++) begin rand_store(); tick(); end
    st_valid = 0; tick(); tick(); tick();
    sram_full = 1;
    for (int i = 0; i < 3; i++) begin rand_store(); tick(); end
    st_valid = 0;
    ld_addr = st_addr;
    rst = 1; tick(); rst = 0; sram_full = 0;
    check("rst_we",        we,          0);
    check("rst_req",       req,         0);
    check("rst_data",      data,        0);
    check("rst_ready",     st_ready,    1);
    check("rst_idle",      idle,        1);
    check("rst_conflict",  ld_conflict, 0);
    check("rst_underflow", underflow,   0);
    sram_end = 1; tick(); sram_end = 0;
    check("underflow_set", underflow, 1);
    tick(); tick(); tick();
    check("underflow_sticky", underflow, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
